ringbuf_reader: RTL and testbench
=================================

Name: ringbuf_reader

Overview:
Read-side adapter for the ringbuf FIFO. It pulls entries through the ringbuf read port (data, empty, read-enable) and presents them downstream as a registered valid/ready stream. A 2-entry prefetch/skid buffer sustains one entry per cycle. No combinational path runs from downstream i_ready to o_fifo_re. Sits between a ringbuf instance (e.g. free-list or fetch queue) and its consumer stage (rename/decode).

Parameters:
WIDTH, 8, bit width of one entry (matches ringbuf WIDTH)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  asynchronous, active-high reset
i_fifo_data  input  WIDTH  ringbuf head entry (ringbuf o_data); valid whenever i_fifo_empty=0
i_fifo_empty  input  1  ringbuf empty flag (ringbuf o_empty)
o_fifo_re  output  1  read enable to ringbuf (ringbuf i_re); head popped at the next rising edge
o_data  output  WIDTH  downstream entry, oldest buffered
o_valid  output  1  o_data holds a valid entry
i_ready  input  1  downstream accepts o_data this cycle
i_flush  input  1  synchronous discard of all buffered entries
o_count  output  2  entries currently buffered (0..2)

Behaviour:
- Clock is i_clk. Reset is i_rst: asynchronous assert, active-high.
- Ringbuf read contract: i_fifo_data is show-ahead (head visible combinationally). A read with o_fifo_re=1 at an edge consumes that head. The next head appears after the edge.
- State: slot H (head), slot T (tail), 2-bit cnt. o_count = cnt.
- Reset values while i_rst=1:
  - cnt=0, H=0, T=0
  - o_valid=0, o_data=0, o_count=0
  - o_fifo_re=0, forced low regardless of i_fifo_empty
- Outputs:
  - o_valid = (cnt != 0)
  - o_data = H, a registered value
- pop = o_valid & i_ready & ~i_flush.
- o_fifo_re = ~i_rst & ~i_fifo_empty & ~i_flush & (cnt < 2). It depends only on registered cnt and upstream/flush inputs, never on i_ready.
- push = o_fifo_re. i_fifo_data is captured at the same edge the ringbuf pops it.
- Next state, with r = cnt - pop:
  - pop and cnt=2: H <= T
  - push and r=0: H <= i_fifo_data
  - push and r=1: T <= i_fifo_data
  - cnt <= cnt + push - pop
- Simultaneous push+pop:
  - cnt=1: H replaced by the incoming entry, cnt stays 1.
  - cnt=2: push is impossible because re=0.
- Throughput: steady state cnt=1 with push+pop every cycle gives 1 entry/cycle. First entry latency: o_fifo_re at edge k gives o_valid=1 after edge k, i.e. 1 cycle.
- Full (cnt=2): o_fifo_re=0 and the ringbuf is not read. A downstream pop drops cnt to 1; re re-asserts next cycle if not empty.
- Empty upstream: o_fifo_re=0; buffered entries still drain normally.
- i_flush=1 at an edge: cnt <= 0 and buffered entries are discarded. No ringbuf read and no downstream transfer happen that cycle. o_valid=0 the following cycle.
- Ordering: entries leave strictly in ringbuf read order. No duplication or loss except on flush.
- H/T contents when not valid are don't-care for function. They must hold their last value (no X) after reset.
- i_rst asserted mid-stream: immediate clear as per reset values. Buffered entries are lost. The ringbuf is reset by the same i_rst in system use.

Test Plan:
- Reset: i_rst=1, upstream non-empty with data 4'hF -> o_valid=0, o_count=0, o_fifo_re=0. After i_rst falls: o_fifo_re=1 in the first cycle, o_valid=1 with o_data=4'hF one edge later.
- Streaming (WIDTH=4): ringbuf preloaded with 8 entries 4'hF,0,1,...,6, i_ready=1 constantly -> o_data sequence F,0,1,..,6 on 8 consecutive cycles. o_count stays 1. Then o_valid=0 and o_fifo_re=0.
- Backpressure: same preload, i_ready=0 for 5 cycles -> exactly 2 reads issued, o_count=2, o_data=F held, o_fifo_re=0. Release i_ready -> F,0,1,... with no gap after the first cycle.
- Alternating i_ready (1,0,1,0) with 8 entries -> all 8 entries delivered in order. o_count never exceeds 2. The ringbuf is never read while empty.
- Flush: o_count=2 holding F,0, assert i_flush one cycle with i_ready=1 -> no transfer, no ringbuf read. Next cycle o_count=0, o_valid=0. Then reading resumes with entry 1.
- Async reset mid-stream: assert i_rst between edges while o_count=2 -> o_valid and o_count go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ringbuf_reader.sv
// Read-side adapter for the ringbuf FIFO: prefetches up to two entries into a
// head/tail skid buffer and presents them as a registered valid/ready stream.
module ringbuf_reader #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_fifo_data,
  input  logic             i_fifo_empty,
  output logic             o_fifo_re,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       r_s;
  logic             pop_s;
  logic             push_s;

  // Read enable uses only registered occupancy, so i_ready never reaches the ringbuf.
  assign push_s    = ~i_rst & ~i_fifo_empty & ~i_flush & (cnt_q < 2'd2);
  assign o_fifo_re = push_s;
  assign pop_s     = o_valid & i_ready & ~i_flush;
  assign r_s       = cnt_q - {1'b0, pop_s};

  assign o_valid = (cnt_q != 2'd0);
  assign o_data  = h_q;
  assign o_count = cnt_q;

  // Next-state for the skid slots and occupancy.
  always_comb begin
    h_d   = h_q;
    t_d   = t_q;
    cnt_d = cnt_q;
    if (i_flush) begin
      cnt_d = 2'd0;
    end else begin
      if (pop_s && (cnt_q == 2'd2)) begin
        h_d = t_q;
      end else begin
        h_d = h_q;
      end
      if (push_s && (r_s == 2'd0)) begin
        h_d = i_fifo_data;
      end else if (push_s && (r_s == 2'd1)) begin
        t_d = i_fifo_data;
      end else begin
        t_d = t_q;
      end
      cnt_d = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_q   <= '0;
      t_q   <= '0;
      cnt_q <= 2'd0;
    end else begin
      h_q   <= h_d;
      t_q   <= t_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ringbuf_reader.sv
// Directed bench for ringbuf_reader (WIDTH=4) with a behavioural show-ahead
// ringbuf on the upstream side.
module tb_ringbuf_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_re;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic       flush;
  logic [1:0] count;

  logic [3:0] mem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int bad_reads = 0;
  int n_pass = 0;
  int n_total = 0;
  int snap;
  int idx;
  int cyc;
  logic [3:0] exp_seq [0:7];

  ringbuf_reader #(.WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty),
    .o_fifo_re(fifo_re), .o_data(data), .o_valid(valid), .i_ready(ready),
    .i_flush(flush), .o_count(count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr[5:0]];

  // Upstream ringbuf: pop head on a read edge; flag any read while empty.
  always @(posedge clk) begin
    if (fifo_re) begin
      rd_ptr <= rd_ptr + 1;
      if (fifo_empty) bad_reads <= bad_reads + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [3:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;
    exp_seq[0] = 4'hF;
    for (int i = 1; i < 8; i++) exp_seq[i] = 4'(i - 1);
    for (int i = 0; i < 8; i++) preload(exp_seq[i]);

    // Reset with upstream non-empty
    @(negedge clk); @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_re", {31'd0, fifo_re}, 32'd0);
    chk("rst_data", {28'd0, data}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_re", {31'd0, fifo_re}, 32'd1);
    step();
    chk("first_valid", {31'd0, valid}, 32'd1);
    chk("first_data", {28'd0, data}, 32'hF);

    // Streaming with ready held high
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", {31'd0, valid}, 32'd1);
      chk("stream_data", {28'd0, data}, {28'd0, exp_seq[i]});
      chk("stream_count", {30'd0, count}, 32'd1);
      step();
    end
    chk("stream_end_valid", {31'd0, valid}, 32'd0);
    chk("stream_end_re", {31'd0, fifo_re}, 32'd0);

    // Backpressure
    ready = 1'b0;
    snap = rd_ptr;
    for (int i = 0; i < 8; i++) preload(exp_seq[i]);
    for (int i = 0; i < 5; i++) step();
    chk("bp_reads", 32'(rd_ptr - snap), 32'd2);
    chk("bp_count", {30'd0, count}, 32'd2);
    chk("bp_data", {28'd0, data}, 32'hF);
    chk("bp_re", {31'd0, fifo_re}, 32'd0);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_rel_valid", {31'd0, valid}, 32'd1);
      chk("bp_rel_data", {28'd0, data}, {28'd0, exp_seq[i]});
      step();
    end
    chk("bp_end_valid", {31'd0, valid}, 32'd0);

    // Alternating ready
    for (int i = 0; i < 8; i++) preload(4'(8 + i));
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 40) begin
      ready = (cyc % 2 == 0);
      #1;
      if (count > 2'd2) chk("alt_count_le2", {30'd0, count}, 32'd2);
      if (valid && ready) begin
        chk("alt_data", {28'd0, data}, 32'(8 + idx));
        idx++;
      end
      step();
      cyc++;
    end
    chk("alt_delivered", 32'(idx), 32'd8);
    chk("alt_drained", {31'd0, valid}, 32'd0);

    // Flush with two entries buffered
    ready = 1'b0;
    preload(4'hF); preload(4'h0); preload(4'h1);
    step(); step();
    chk("fl_count", {30'd0, count}, 32'd2);
    chk("fl_data", {28'd0, data}, 32'hF);
    flush = 1'b1; ready = 1'b1;
    #1;
    chk("fl_re_low", {31'd0, fifo_re}, 32'd0);
    snap = rd_ptr;
    step();
    flush = 1'b0; ready = 1'b0;
    chk("fl_post_count", {30'd0, count}, 32'd0);
    chk("fl_post_valid", {31'd0, valid}, 32'd0);
    chk("fl_no_read", 32'(rd_ptr - snap), 32'd0);
    step();
    chk("fl_resume_valid", {31'd0, valid}, 32'd1);
    chk("fl_resume_data", {28'd0, data}, 32'h1);
    ready = 1'b1;
    step();
    ready = 1'b0;

    // Asynchronous reset mid-stream
    preload(4'h3); preload(4'h5);
    step(); step();
    chk("ar_pre_count", {30'd0, count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, valid}, 32'd0);
    chk("ar_count", {30'd0, count}, 32'd0);
    chk("ar_data", {28'd0, data}, 32'd0);
    chk("ar_re", {31'd0, fifo_re}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    chk("no_empty_reads", 32'(bad_reads), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
